// File: rtl/simon_game_core.sv
// simon_game_core: Simon-says game engine. Plays back a growing pseudo-random
// sequence on the lamps, then checks the player's presses against it with a
// per-press timeout. The sequence is regenerated from a seeded LFSR each pass.
//
// Ports:
//   clk     system clock
//   reset   asynchronous, active-high; clears all state
//   tick    one-cycle timing enable; every duration counts tick pulses
//   start   start level; its rising edge starts a game when not busy
//   button  debounced buttons, active-high, one per channel
//   colour  lamp drive, one per channel
//   score   number of completed rounds
//   busy    game in progress
//   win     all MAX_LEN rounds completed
//   lose    wrong press, multiple press, or timeout
module simon_game_core #(
    parameter int unsigned N_BTN         = 4,
    parameter int unsigned MAX_LEN       = 16,
    parameter int unsigned SHOW_TICKS    = 5,
    parameter int unsigned GAP_TICKS     = 2,
    parameter int unsigned TIMEOUT_TICKS = 50,
    parameter logic [15:0] SEED          = 16'hACE1,
    localparam int unsigned SW           = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic [N_BTN-1:0] button,
    output logic [N_BTN-1:0] colour,
    output logic [SW-1:0]    score,
    output logic             busy,
    output logic             win,
    output logic             lose
);

    localparam int unsigned LB   = $clog2(N_BTN);
    localparam int unsigned CMAX = (SHOW_TICKS > GAP_TICKS)
                                   ? ((SHOW_TICKS > TIMEOUT_TICKS) ? SHOW_TICKS : TIMEOUT_TICKS)
                                   : ((GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS);
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam logic [15:0] MASK = 16'hB400;

    typedef enum logic [3:0] {
        IDLE, PREP, SHOW_ON, SHOW_OFF, IN_WAIT, IN_REL, ROUND_OK, WIN, LOSE
    } state_t;

    // Galois step for x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? MASK : 16'h0000);
    endfunction

    function automatic logic [N_BTN-1:0] onehot(input logic [LB-1:0] sel);
        return N_BTN'(1) << sel;
    endfunction

    state_t           state;
    logic [15:0]      free_lfsr;
    logic [15:0]      game_seed;
    logic [15:0]      seq_lfsr;
    logic             start_d;
    logic [N_BTN-1:0] button_d;
    logic [SW-1:0]    len;
    logic [SW-1:0]    idx;
    logic [CW-1:0]    cnt;

    logic             start_edge;
    logic             press_edge;
    logic [N_BTN-1:0] exp_col;
    logic [15:0]      seq_step;
    logic             last;

    // Edge detects and the currently expected element
    always_comb begin
        start_edge = start & ~start_d;
        press_edge = (button != '0) && (button_d == '0);
        exp_col    = onehot(seq_lfsr[LB-1:0]);
        seq_step   = lfsr_next(seq_lfsr);
        last       = (idx == len - SW'(1));
    end

    // Game FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            free_lfsr <= SEED;
            game_seed <= SEED;
            seq_lfsr  <= SEED;
            start_d   <= 1'b0;
            button_d  <= '0;
            len       <= '0;
            idx       <= '0;
            cnt       <= '0;
            colour    <= '0;
            score     <= '0;
            busy      <= 1'b0;
            win       <= 1'b0;
            lose      <= 1'b0;
        end else begin
            free_lfsr <= lfsr_next(free_lfsr);
            start_d   <= start;
            button_d  <= button;

            case (state)
                IDLE, WIN, LOSE: begin
                    // WIN/LOSE hold their lamp pattern; IDLE echoes the buttons
                    if (state == IDLE) colour <= button;
                    if (start_edge) begin
                        game_seed <= free_lfsr;
                        len       <= SW'(1);
                        score     <= '0;
                        win       <= 1'b0;
                        lose      <= 1'b0;
                        busy      <= 1'b1;
                        colour    <= '0;
                        state     <= PREP;
                    end
                end

                PREP: begin
                    seq_lfsr <= game_seed;
                    idx      <= '0;
                    cnt      <= '0;
                    colour   <= onehot(game_seed[LB-1:0]);
                    state    <= SHOW_ON;
                end

                SHOW_ON: begin
                    if (tick) begin
                        if (cnt == CW'(SHOW_TICKS - 1)) begin
                            cnt    <= '0;
                            colour <= '0;
                            state  <= SHOW_OFF;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                SHOW_OFF: begin
                    if (tick) begin
                        if (cnt == CW'(GAP_TICKS - 1)) begin
                            cnt <= '0;
                            if (last) begin
                                // Rewind the sequence for the input phase
                                seq_lfsr <= game_seed;
                                idx      <= '0;
                                colour   <= button;
                                state    <= IN_WAIT;
                            end else begin
                                seq_lfsr <= seq_step;
                                idx      <= idx + SW'(1);
                                colour   <= onehot(seq_step[LB-1:0]);
                                state    <= SHOW_ON;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                IN_WAIT: begin
                    colour <= button;
                    // A press on the expiry tick wins over the timeout
                    if (press_edge) begin
                        if (button == exp_col) begin
                            state <= IN_REL;
                        end else begin
                            colour <= exp_col;
                            lose   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= LOSE;
                        end
                    end else if (tick) begin
                        if (cnt == CW'(TIMEOUT_TICKS - 1)) begin
                            colour <= exp_col;
                            lose   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= LOSE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                IN_REL: begin
                    colour <= button;
                    if (button == '0) begin
                        if (last) begin
                            state <= ROUND_OK;
                        end else begin
                            idx      <= idx + SW'(1);
                            seq_lfsr <= seq_step;
                            cnt      <= '0;
                            state    <= IN_WAIT;
                        end
                    end
                end

                ROUND_OK: begin
                    score <= len;
                    if (len == SW'(MAX_LEN)) begin
                        colour <= '1;
                        win    <= 1'b1;
                        busy   <= 1'b0;
                        state  <= WIN;
                    end else begin
                        colour <= '0;
                        len    <= len + SW'(1);
                        state  <= PREP;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_game_core.sv
// Scoreboard bench for simon_game_core: stimulus tasks push cycle-tagged
// expectations into a queue; a negedge monitor pops and compares them.
module tb_simon_game_core;

    localparam int unsigned SW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic          start;
    logic [3:0]    button;
    logic [3:0]    colour;
    logic [SW-1:0] score;
    logic          busy;
    logic          win;
    logic          lose;

    simon_game_core #(
        .N_BTN(4), .MAX_LEN(4), .SHOW_TICKS(2), .GAP_TICKS(1),
        .TIMEOUT_TICKS(8), .SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .button(button),
        .colour(colour), .score(score), .busy(busy), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       at;
        logic [3:0] col;
        bit       cc;
        int       sc;
        bit       b;
        bit       w;
        bit       l;
        string    name;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_free;
    logic [15:0] gs;

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Free-running LFSR model, used to predict the latched game seed
    always @(posedge clk or posedge reset) begin
        if (reset) m_free <= 16'hACE1;
        else       m_free <= lstep(m_free);
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] exp_at(input int k);
        logic [15:0] v;
        logic [3:0]  one;
        v = gs;
        for (int i = 0; i < k; i++) v = lstep(v);
        one = 4'b0001;
        return one << v[1:0];
    endfunction

    task automatic push(input int at, input logic [3:0] col, input bit cc, input int sc,
                        input bit b, input bit w, input bit l, input string name);
        exp_t e;
        e.at = at; e.col = col; e.cc = cc; e.sc = sc;
        e.b = b; e.w = w; e.l = l; e.name = name;
        q.push_back(e);
    endtask

    // Monitor: compare every expectation due in this cycle
    exp_t me;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            me = q.pop_front();
            checks++;
            if (me.at != cyc || (me.cc && colour !== me.col) || score !== SW'(me.sc) ||
                busy !== me.b || win !== me.w || lose !== me.l) begin
                errors++;
                $display("FAIL %s cycle %0d: colour=%b score=%0d busy=%b win=%b lose=%b, required colour=%b(chk %0d) score=%0d busy=%b win=%b lose=%b at cycle %0d",
                         me.name, cyc, colour, score, busy, win, lose,
                         me.col, me.cc, me.sc, me.b, me.w, me.l, me.at);
            end
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game(input int sc_prev, input bit w_prev, input bit l_prev);
        start = 1'b1;
        gs    = m_free;
        push(cyc, colour, 1'b0, sc_prev, 1'b0, w_prev, l_prev, "pre_start");
        push(cyc + 1, 4'b0000, 1'b0, 0, 1'b1, 1'b0, 1'b0, "start_busy");
        adv();
        start = 1'b0;
    endtask

    // Entered in the PREP cycle; leaves in the first IN_WAIT cycle
    task automatic playback(input int len, input bit poke);
        int p;
        p = cyc;
        for (int k = 0; k < len; k++) begin
            push(p + 1 + 3 * k, exp_at(k), 1'b1, len - 1, 1'b1, 1'b0, 1'b0, "show_on");
            push(p + 2 + 3 * k, exp_at(k), 1'b1, len - 1, 1'b1, 1'b0, 1'b0, "show_on_2");
            push(p + 3 + 3 * k, 4'b0000,  1'b1, len - 1, 1'b1, 1'b0, 1'b0, "show_off");
        end
        push(p + 1 + 3 * len, button, 1'b1, len - 1, 1'b1, 1'b0, 1'b0, "wait_echo");
        for (int i = 1; i <= 3 * len + 1; i++) begin
            adv();
            if (poke && i == 1) start = 1'b1;
            if (poke && i == 2) start = 1'b0;
        end
    endtask

    // Entered in the first IN_WAIT cycle; leaves in PREP or WIN
    task automatic answer(input int len);
        for (int k = 0; k < len; k++) begin
            button = exp_at(k);
            push(cyc + 1, exp_at(k), 1'b1, len - 1, 1'b1, 1'b0, 1'b0, "press_echo");
            adv();
            button = 4'b0000;
            if (k == len - 1) begin
                push(cyc + 1, 4'b0000, 1'b0, len - 1, 1'b1, 1'b0, 1'b0, "round_ok");
                if (len == 4) push(cyc + 2, 4'b1111, 1'b1, len, 1'b0, 1'b1, 1'b0, "win");
                else          push(cyc + 2, 4'b0000, 1'b0, len, 1'b1, 1'b0, 1'b0, "next_prep");
                adv();
                adv();
            end else begin
                push(cyc + 1, 4'b0000, 1'b1, len - 1, 1'b1, 1'b0, 1'b0, "release_wait");
                adv();
            end
        end
    endtask

    initial begin
        logic [3:0] e0;
        logic [3:0] bad;
        reset  = 1'b1;
        tick   = 1'b1;
        start  = 1'b0;
        button = 4'b0000;

        // Reset state
        adv();
        push(cyc, 4'b0000, 1'b1, 0, 1'b0, 1'b0, 1'b0, "reset_state");
        adv();
        reset = 1'b0;
        push(cyc, 4'b0000, 1'b1, 0, 1'b0, 1'b0, 1'b0, "reset_release");
        adv();

        // Full game to a win
        start_game(0, 1'b0, 1'b0);
        for (int len = 1; len <= 4; len++) begin
            playback(len, 1'b0);
            answer(len);
        end
        push(cyc + 1, 4'b1111, 1'b1, 4, 1'b0, 1'b1, 1'b0, "win_hold");
        adv();

        // Wrong one-hot press in round 2
        start_game(4, 1'b1, 1'b0);
        playback(1, 1'b0);
        answer(1);
        playback(2, 1'b0);
        e0  = exp_at(0);
        bad = {e0[2:0], e0[3]};
        button = bad;
        push(cyc + 1, e0, 1'b1, 1, 1'b0, 1'b0, 1'b1, "lose_wrong");
        adv();
        button = 4'b0000;
        push(cyc + 1, e0, 1'b1, 1, 1'b0, 1'b0, 1'b1, "lose_hold");
        adv();

        // Two buttons at once
        start_game(1, 1'b0, 1'b1);
        playback(1, 1'b0);
        e0  = exp_at(0);
        bad = e0 | ((e0 == 4'b1000) ? 4'b0001 : (e0 << 1));
        button = bad;
        push(cyc + 1, e0, 1'b1, 0, 1'b0, 1'b0, 1'b1, "lose_multi");
        adv();
        button = 4'b0000;
        adv();

        // No press: timeout after 8 ticks
        start_game(0, 1'b0, 1'b1);
        playback(1, 1'b0);
        push(cyc + 7, 4'b0000, 1'b1, 0, 1'b1, 1'b0, 1'b0, "pre_timeout");
        push(cyc + 8, exp_at(0), 1'b1, 0, 1'b0, 1'b0, 1'b1, "timeout");
        repeat (8) adv();

        // Press on the expiry tick is accepted, then reset mid-SHOW_ON
        start_game(0, 1'b0, 1'b1);
        playback(1, 1'b0);
        repeat (7) adv();
        button = exp_at(0);
        push(cyc + 1, exp_at(0), 1'b1, 0, 1'b1, 1'b0, 1'b0, "late_press");
        adv();
        button = 4'b0000;
        push(cyc + 1, 4'b0000, 1'b0, 0, 1'b1, 1'b0, 1'b0, "late_round_ok");
        push(cyc + 2, 4'b0000, 1'b0, 1, 1'b1, 1'b0, 1'b0, "late_next_prep");
        adv();
        adv();
        push(cyc + 1, exp_at(0), 1'b1, 1, 1'b1, 1'b0, 1'b0, "r2_show_on");
        adv();
        adv();
        reset = 1'b1;
        push(cyc, 4'b0000, 1'b1, 0, 1'b0, 1'b0, 1'b0, "reset_async");
        adv();
        reset = 1'b0;
        push(cyc, 4'b0000, 1'b1, 0, 1'b0, 1'b0, 1'b0, "post_reset");
        adv();

        // Button held from IDLE into IN_WAIT; start pulse during playback
        button = 4'b0100;
        push(cyc + 1, 4'b0100, 1'b1, 0, 1'b0, 1'b0, 1'b0, "idle_echo");
        adv();
        start_game(0, 1'b0, 1'b0);
        playback(1, 1'b1);
        push(cyc + 7, 4'b0100, 1'b1, 0, 1'b1, 1'b0, 1'b0, "held_no_press");
        push(cyc + 8, exp_at(0), 1'b1, 0, 1'b0, 1'b0, 1'b1, "held_timeout");
        repeat (8) adv();
        button = 4'b0000;

        repeat (3) adv();
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish within 10000 cycles");
        $fatal(1);
    end

endmodule
